// File: rtl/mips_pc_sequencer.sv
// rtl/mips_pc_sequencer.sv - fetch PC register and ID-stage branch/jump redirect sequencer
// Optional feature macro: MIPS_PC_SEQUENCER_ALIGN_CHECK_EN (align_fault output, target word-aligned on load)
module mips_pc_sequencer #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0040_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          control_action,
    input  logic [1:0]          control_condition,
    input  logic                id_valid,
    input  logic [PC_WIDTH-1:0] id_pc,
    input  logic [15:0]         id_imm16,
    input  logic [25:0]         id_index26,
    input  logic [PC_WIDTH-1:0] rs_value,
    input  logic [PC_WIDTH-1:0] rt_value,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] pc,
    output logic                flush,
    output logic                taken
`ifdef MIPS_PC_SEQUENCER_ALIGN_CHECK_EN
    ,
    output logic                align_fault
`endif
);

    localparam logic [1:0] ACT_INC    = 2'd0;
    localparam logic [1:0] ACT_JUMP   = 2'd1;
    localparam logic [1:0] ACT_JUMPR  = 2'd2;
    localparam logic [1:0] ACT_BRANCH = 2'd3;
    localparam logic [1:0] COND_EQ    = 2'd1;
    localparam logic [1:0] COND_NE    = 2'd2;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] pending, pending_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] id_pc_plus4;
    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                cond_met;
    logic                decide;
    logic                redirect;

    always_comb begin
        id_pc_plus4   = id_pc + PC_WIDTH'(4);
        branch_target = id_pc_plus4 + {{(PC_WIDTH-18){id_imm16[15]}}, id_imm16, 2'b00};
        jump_target   = {id_pc_plus4[PC_WIDTH-1:28], id_index26, 2'b00};
        cond_met      = ((control_condition == COND_EQ) && (rs_value == rt_value)) ||
                        ((control_condition == COND_NE) && (rs_value != rt_value));
        target = branch_target;
        decide = 1'b0;
        case (control_action)
            ACT_JUMP:   begin target = jump_target; decide = 1'b1;     end
            ACT_JUMPR:  begin target = rs_value;    decide = 1'b1;     end
            ACT_BRANCH: begin target = branch_target; decide = cond_met; end
            ACT_INC:    begin target = branch_target; decide = 1'b0;   end
            default:    begin target = branch_target; decide = 1'b0;   end
        endcase
        taken = !reset && id_valid && (state == RUN) && decide;
    end

    // A pending redirect always wins over whatever ID shows in the releasing cycle.
    always_comb begin
        state_next      = state;
        pending_next    = pending;
        pc_next         = pc;
        redirect        = 1'b0;
        redirect_target = target;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (taken) redirect = 1'b1;
                    else       pc_next  = pc + PC_WIDTH'(4);
                end else if (taken) begin
                    pending_next = target;
                    state_next   = PENDING;
                end
            end
            PENDING: begin
                if (!stall) begin
                    redirect        = 1'b1;
                    redirect_target = pending;
                    state_next      = RUN;
                end
            end
            default: state_next = RUN;
        endcase
`ifdef MIPS_PC_SEQUENCER_ALIGN_CHECK_EN
        if (redirect) pc_next = {redirect_target[PC_WIDTH-1:2], 2'b00};
`else
        if (redirect) pc_next = redirect_target;
`endif
        flush = redirect && !reset;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            pending <= '0;
            pc      <= RESET_VECTOR;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            pc      <= pc_next;
        end
    end

`ifdef MIPS_PC_SEQUENCER_ALIGN_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            align_fault <= 1'b0;
        else if (redirect && (redirect_target[1:0] != 2'b00))
            align_fault <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// tb/tb_mips_pc_sequencer.sv - scoreboard bench for mips_pc_sequencer with behavioural reference model
module tb_mips_pc_sequencer;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  control_action, control_condition;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [15:0] id_imm16;
    logic [25:0] id_index26;
    logic [31:0] rs_value, rt_value;
    logic        stall;
    logic [31:0] pc;
    logic        flush, taken;
    logic        align_fault;

    mips_pc_sequencer #(.PC_WIDTH(32), .RESET_VECTOR(RV)) dut (
        .clock(clock), .reset(reset),
        .control_action(control_action), .control_condition(control_condition),
        .id_valid(id_valid), .id_pc(id_pc), .id_imm16(id_imm16), .id_index26(id_index26),
        .rs_value(rs_value), .rt_value(rt_value), .stall(stall),
        .pc(pc), .flush(flush), .taken(taken)
`ifdef MIPS_PC_SEQUENCER_ALIGN_CHECK_EN
        , .align_fault(align_fault)
`endif
    );

`ifndef MIPS_PC_SEQUENCER_ALIGN_CHECK_EN
    assign align_fault = 1'b0;
`endif

    always #5 clock = ~clock;

    typedef struct {
        logic        taken;
        logic        flush;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          failed = 0;

    logic [31:0] m_pc = RV;
    logic        m_pend = 1'b0;
    logic [31:0] m_tgt = '0;
    logic        m_fault = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_load(input logic [31:0] t);
`ifdef MIPS_PC_SEQUENCER_ALIGN_CHECK_EN
        if (t % 4 != 0) m_fault = 1'b1;
        m_pc = t - (t % 4);
`else
        m_pc = t;
`endif
    endfunction

    // Called at a falling edge; applies one cycle of inputs and returns at the next falling edge.
    task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] c,
                         input logic [31:0] ipc, input logic [15:0] imm, input logic [25:0] idx,
                         input logic [31:0] rs, input logic [31:0] rt, input logic st);
        exp_t        e;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] offs;
        id_valid = v; control_action = a; control_condition = c; id_pc = ipc;
        id_imm16 = imm; id_index26 = idx; rs_value = rs; rt_value = rt; stall = st;
        offs  = {{16{imm[15]}}, imm};
        redir = 1'b0;
        tgt   = 32'h0;
        if (v) begin
            if (a == 2'd1) begin redir = 1'b1; tgt = ((ipc + 4) & 32'hF000_0000) + (32'(idx) * 4); end
            if (a == 2'd2) begin redir = 1'b1; tgt = rs; end
            if (a == 2'd3) begin
                redir = (c == 2'd1 && rs == rt) || (c == 2'd2 && rs != rt);
                tgt   = ipc + 4 + offs * 4;
            end
        end
        e.taken = redir && !m_pend;
        e.flush = 1'b0;
        if (st) begin
            if (e.taken) begin m_pend = 1'b1; m_tgt = tgt; end
        end else if (m_pend) begin
            model_load(m_tgt);
            m_pend  = 1'b0;
            e.flush = 1'b1;
        end else if (e.taken) begin
            model_load(tgt);
            e.flush = 1'b1;
        end else begin
            m_pc = m_pc + 4;
        end
        e.pc    = m_pc;
        e.fault = m_fault;
        sb.push_back(e);
        @(negedge clock);
    endtask

    task automatic inc_cycle();
        drive(1'b0, 2'd3, 2'd1, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Entered and left at a falling edge; reset hits mid-cycle, after the rising edge.
    task automatic do_reset();
        stall = 1'b1; id_valid = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b1; id_valid = 1'b1; control_action = 2'd1; stall = 1'b0;
        m_pc = RV; m_pend = 1'b0; m_fault = 1'b0;
        #1;
        check("reset_pc", pc, RV);
        check("reset_taken", 32'(taken), 32'h0);
        check("reset_flush", 32'(flush), 32'h0);
        check("reset_fault", 32'(align_fault), 32'h0);
        @(negedge clock);
        reset = 1'b0; id_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("taken", 32'(taken), 32'(e.taken));
                check("flush", 32'(flush), 32'(e.flush));
                @(posedge clock);
                #1;
                check("pc", pc, e.pc);
                check("align_fault", 32'(align_fault), 32'(e.fault));
            end
        end
    end

    initial begin : stimulus
        logic [31:0] r_pc, r_rs, r_rt;
        reset = 1'b1; stall = 1'b0; id_valid = 1'b0; control_action = 2'd0;
        control_condition = 2'd0; id_pc = '0; id_imm16 = '0; id_index26 = '0;
        rs_value = '0; rt_value = '0;
        @(negedge clock);
        check("initial_pc", pc, RV);
        reset = 1'b0;
        repeat (4) inc_cycle();
        do_reset();
        repeat (2) inc_cycle();
        drive(1'b1, 2'd3, 2'd1, 32'h0040_0100, 16'hFFFC, 26'h0, 32'd5, 32'd5, 1'b0);
        drive(1'b1, 2'd3, 2'd2, 32'h0040_0100, 16'h0010, 26'h0, 32'd7, 32'd7, 1'b0);
        drive(1'b1, 2'd3, 2'd3, 32'h0040_0100, 16'h0010, 26'h0, 32'd1, 32'd2, 1'b0);
        drive(1'b1, 2'd1, 2'd0, 32'h1000_0000, 16'h0, 26'h0000040, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 2'd2, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0040_2000, 32'h0, 1'b0);
        repeat (3) drive(1'b1, 2'd2, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0050_0000, 32'h0, 1'b1);
        drive(1'b1, 2'd1, 2'd0, 32'h1000_0000, 16'h0, 26'h0000123, 32'h0, 32'h0, 1'b0);
        inc_cycle();
        drive(1'b1, 2'd2, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0060_0000, 32'h0, 1'b1);
        do_reset();
        repeat (2) inc_cycle();
        drive(1'b1, 2'd2, 2'd0, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);
        inc_cycle();
        drive(1'b1, 2'd2, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0040_0002, 32'h0, 1'b0);
        repeat (3) inc_cycle();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 2) do_reset();
            r_pc = $urandom & 32'hFFFF_FFFC;
            r_rs = ($urandom_range(9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            r_rt = ($urandom_range(1) == 0) ? r_rs : $urandom;
            drive($urandom_range(9) < 8, 2'($urandom_range(3)), 2'($urandom_range(3)), r_pc,
                  16'($urandom), 26'($urandom), r_rs, r_rt, $urandom_range(9) < 3);
        end
        stall = 1'b1; id_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mips_pc_sequencer.md
Name: mips_pc_sequencer

Overview:
- Consumer of the IF/ID PC control bundle (action + condition) produced by the ID-stage PC control generator.
- Owns the architectural fetch PC register and resolves the ID-stage branch or jump decision.
- Produces the next fetch address and an IF flush pulse on redirect.
- Sits between ID decode/register read and the instruction-memory address port. Absorbs redirects that arrive while the pipeline is stalled.

Parameters:
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset.
- PC_WIDTH, 32, width of all address datapaths.

Ports:
- clock  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- control_action  input  2  PC action: Inc=0, Jump=1, JumpR=2, Branch=3
- control_condition  input  2  branch condition: None=0, EQ=1, NE=2, 3 reserved (treated as None)
- id_valid  input  1  ID-stage instruction valid; control fields meaningful only when 1
- id_pc  input  PC_WIDTH  PC of the instruction in ID
- id_imm16  input  16  branch offset field
- id_index26  input  26  jump index field
- rs_value  input  PC_WIDTH  forwarded rs operand (compare operand A; JumpR target)
- rt_value  input  PC_WIDTH  forwarded rt operand (compare operand B)
- stall  input  1  hold PC and ID (hazard unit)
- pc  output  PC_WIDTH  current fetch address (registered)
- flush  output  1  kill the IF-stage instruction this cycle
- taken  output  1  ID decision this cycle is a taken redirect (combinational, diagnostic)

Behaviour:
- Reset (asynchronous): pc=RESET_VECTOR, state=RUN, pending target=0. flush=0 and taken=0 while reset is asserted.
- Redirect targets (all arithmetic mod 2^PC_WIDTH):
  - Branch: id_pc+4+(sign_extend(id_imm16)<<2).
  - Jump: {(id_pc+4)[31:28], id_index26, 2'b00}.
  - JumpR: rs_value.
- Decision:
  - taken = id_valid & state==RUN & (action is Jump or JumpR, or action==Branch with (EQ & rs==rt | NE & rs!=rt)).
  - Inc, condition None, or condition 3 gives not taken.
- Two states, RUN and PENDING.
- RUN, stall=0:
  - pc <= taken ? target : pc+4.
  - flush=taken, in the same cycle.
- RUN, stall=1:
  - pc holds; flush=0.
  - If taken, latch target into pending and go to PENDING.
- PENDING, stall=1:
  - pc holds; flush=0.
  - Decisions are ignored, because ID is holding the same instruction.
- PENDING, stall=0:
  - pc <= pending; flush=1; go to RUN.
  - The current ID decision is ignored (pending wins).
- Latency: a redirect takes effect on the next rising edge after the first unstalled cycle. Exactly one flush pulse per redirect.
- Wrap: pc+4 from 32'hFFFF_FFFC gives 32'h0000_0000, with no flag.
- Reset asserted in PENDING discards the pending target.
- id_valid=0: treated as Inc regardless of the control fields.

Optional Feature:
MIPS_PC_SEQUENCER_ALIGN_CHECK_EN
- Enabled:
  - Adds output align_fault (1 bit, registered, sticky until reset).
  - Sets align_fault when a redirect is applied (pc loaded from target or pending) with target[1:0]!=0.
  - In that case pc is loaded with {target[PC_WIDTH-1:2],2'b00}.
- Disabled:
  - No align_fault port.
  - The target is loaded unmodified.

Test Plan:
- Reset: assert reset mid-cycle with pc=0x00400010 -> pc=0x00400000 immediately. After release and stall=0, pc steps 0x00400004, 0x00400008.
- Branch taken: id_pc=0x00400100, Branch/EQ, rs=rt=5, imm16=0xFFFC -> taken=1, flush=1, next pc=0x004000F4.
- Branch not taken: Branch/NE, rs=rt=7 -> taken=0, flush=0, pc+4. Condition 3 with rs!=rt also gives not taken.
- Jump and JumpR:
  - Jump, id_pc=0x1000_0000, index26=0x0000040 -> pc=0x1000_0100.
  - JumpR, rs=0x0040_2000 -> pc=0x0040_2000, one flush each.
- Stalled redirect: JumpR rs=0x00500000 with stall=1 for 3 cycles -> pc constant, flush=0. On the first stall=0 cycle, flush=1 and next pc=0x00500000. A new Jump presented in that same cycle is ignored.
- Wrap / align:
  - pc=0xFFFFFFFC, Inc -> pc=0x00000000.
  - With MIPS_PC_SEQUENCER_ALIGN_CHECK_EN, JumpR rs=0x00400002 -> pc=0x00400000, align_fault=1, and it stays 1 until reset.
